cpu_control_seq: RTL

Multi-cycle control sequencer for the 8-bit CPU. It drives the load enables of the datapath's load-enabled registers (PC, MAR, IR, A, B, OUT, FLAGS), the memory write strobe and the shared-bus source select. It runs a fetch/execute step counter indexed by the opcode held in IR. It is the only block that asserts register loads in the core.

---
 rtl/cpu_control_seq_if.sv | 46 ++++
 rtl/cpu_control_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_seq_if.sv
// Control-sequencer interface: CPU status inputs and datapath control strobes.
// The step input is present only when CPU_CTRL_SINGLE_STEP_EN is defined.
interface cpu_control_seq_if #(
    parameter int OPW = 4,
    parameter int BSW = 3
);
    logic           run;
    logic [OPW-1:0] ir_op;
    logic           flag_z;
    logic           flag_c;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic           step;
`endif
    logic           pc_l;
    logic           pc_inc;
    logic           mar_l;
    logic           ir_l;
    logic           a_l;
    logic           b_l;
    logic           out_l;
    logic           flags_l;
    logic           mem_we;
    logic           alu_sub;
    logic [BSW-1:0] bus_sel;
    logic           instr_done;
    logic           halted;
    logic           busy;

    modport slave (
`ifdef CPU_CTRL_SINGLE_STEP_EN
        input  step,
`endif
        input  run, ir_op, flag_z, flag_c,
        output pc_l, pc_inc, mar_l, ir_l, a_l, b_l, out_l, flags_l,
        output mem_we, alu_sub, bus_sel, instr_done, halted, busy
    );

    modport master (
`ifdef CPU_CTRL_SINGLE_STEP_EN
        output step,
`endif
        output run, ir_op, flag_z, flag_c,
        input  pc_l, pc_inc, mar_l, ir_l, a_l, b_l, out_l, flags_l,
        input  mem_we, alu_sub, bus_sel, instr_done, halted, busy
    );
endinterface

// File: rtl/cpu_control_seq.sv
// Multi-cycle fetch/execute sequencer (IDLE, T0..T4, HALT); outputs decoded from state and opcode.
// Define CPU_CTRL_SINGLE_STEP_EN to add single-instruction stepping via cs.step.
module cpu_control_seq #(
    parameter int OPW = 4,
    parameter int BSW = 3
) (
    input  logic            clk,
    input  logic            rst,
    cpu_control_seq_if.slave cs
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    localparam logic [BSW-1:0] BUS_NONE = BSW'(0);
    localparam logic [BSW-1:0] BUS_PC   = BSW'(1);
    localparam logic [BSW-1:0] BUS_RAM  = BSW'(2);
    localparam logic [BSW-1:0] BUS_IR   = BSW'(3);
    localparam logic [BSW-1:0] BUS_A    = BSW'(4);
    localparam logic [BSW-1:0] BUS_ALU  = BSW'(5);

    state_t r_state;
    logic   w_last;
    logic   w_start;
    logic   w_long3;
    logic   w_long4;

    // Opcodes needing a T3 (and T4) step; everything else finishes in T2.
    assign w_long3 = (cs.ir_op == OP_LDA) || (cs.ir_op == OP_ADD) ||
                     (cs.ir_op == OP_SUB) || (cs.ir_op == OP_STA);
    assign w_long4 = (cs.ir_op == OP_ADD) || (cs.ir_op == OP_SUB);

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_T2:    w_last = !w_long3;
            S_T3:    w_last = !w_long4;
            S_T4:    w_last = 1'b1;
            default: w_last = 1'b0;
        endcase
    end

`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic r_step_d;
    assign w_start = cs.run | (cs.step & ~r_step_d);
`else
    assign w_start = cs.run;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
`ifdef CPU_CTRL_SINGLE_STEP_EN
            r_step_d <= 1'b0;
`endif
        end else begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
            r_step_d <= cs.step;
`endif
            case (r_state)
                S_IDLE: if (w_start) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   r_state <= S_T2;
                S_T2, S_T3, S_T4: begin
                    if (r_state == S_T2 && cs.ir_op == OP_HLT)
                        r_state <= S_HALT;
                    else if (w_last)
                        r_state <= cs.run ? S_T0 : S_IDLE;
                    else if (r_state == S_T2)
                        r_state <= S_T3;
                    else
                        r_state <= S_T4;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic           w_pc_l, w_pc_inc, w_mar_l, w_ir_l, w_a_l, w_b_l;
    logic           w_out_l, w_flags_l, w_mem_we, w_alu_sub;
    logic [BSW-1:0] w_bus;

    always_comb begin
        w_pc_l    = 1'b0;
        w_pc_inc  = 1'b0;
        w_mar_l   = 1'b0;
        w_ir_l    = 1'b0;
        w_a_l     = 1'b0;
        w_b_l     = 1'b0;
        w_out_l   = 1'b0;
        w_flags_l = 1'b0;
        w_mem_we  = 1'b0;
        w_alu_sub = 1'b0;
        w_bus     = BUS_NONE;
        case (r_state)
            S_T0: begin
                w_bus   = BUS_PC;
                w_mar_l = 1'b1;
            end
            S_T1: begin
                w_bus    = BUS_RAM;
                w_ir_l   = 1'b1;
                w_pc_inc = 1'b1;
            end
            S_T2: begin
                case (cs.ir_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_bus   = BUS_IR;
                        w_mar_l = 1'b1;
                    end
                    OP_LDI: begin
                        w_bus = BUS_IR;
                        w_a_l = 1'b1;
                    end
                    OP_JMP: begin
                        w_bus  = BUS_IR;
                        w_pc_l = 1'b1;
                    end
                    OP_JC: begin
                        w_bus  = BUS_IR;
                        w_pc_l = cs.flag_c;
                    end
                    OP_JZ: begin
                        w_bus  = BUS_IR;
                        w_pc_l = cs.flag_z;
                    end
                    OP_OUT: begin
                        w_bus   = BUS_A;
                        w_out_l = 1'b1;
                    end
                    default: w_bus = BUS_NONE;
                endcase
            end
            S_T3: begin
                case (cs.ir_op)
                    OP_LDA: begin
                        w_bus = BUS_RAM;
                        w_a_l = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_bus     = BUS_RAM;
                        w_b_l     = 1'b1;
                        w_alu_sub = (cs.ir_op == OP_SUB);
                    end
                    OP_STA: begin
                        w_bus    = BUS_A;
                        w_mem_we = 1'b1;
                    end
                    default: w_bus = BUS_NONE;
                endcase
            end
            S_T4: begin
                if (w_long4) begin
                    w_bus     = BUS_ALU;
                    w_a_l     = 1'b1;
                    w_flags_l = 1'b1;
                    w_alu_sub = (cs.ir_op == OP_SUB);
                end
            end
            default: w_bus = BUS_NONE;
        endcase
    end

    assign cs.pc_l       = w_pc_l;
    assign cs.pc_inc     = w_pc_inc;
    assign cs.mar_l      = w_mar_l;
    assign cs.ir_l       = w_ir_l;
    assign cs.a_l        = w_a_l;
    assign cs.b_l        = w_b_l;
    assign cs.out_l      = w_out_l;
    assign cs.flags_l    = w_flags_l;
    assign cs.mem_we     = w_mem_we;
    assign cs.alu_sub    = w_alu_sub;
    assign cs.bus_sel    = w_bus;
    assign cs.instr_done = w_last;
    assign cs.halted     = (r_state == S_HALT);
    assign cs.busy       = (r_state == S_T0) || (r_state == S_T1) || (r_state == S_T2) ||
                           (r_state == S_T3) || (r_state == S_T4);
endmodule
